fetch_unit: RTL and testbench

Instruction fetch front end that produces the `pc` / `enabled` / `instr_raw` triple consumed by the decode stage. Issues in-order word requests to instruction memory over a valid/ready request channel, buffers returned words in a small FIFO, and presents one instruction per cycle to decode. Handles stalls from downstream and PC redirects from execute (branches, jumps, traps, `mret`), discarding in-flight responses from the old path.

---
 rtl/fetch_unit.sv | 139 +++++++++++++
 tb/tb_fetch_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues in-order word requests, buffers returned
// words with their pcs, and presents one instruction per cycle to decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        enabled,
    output logic [31:0] pc,
    output logic [31:0] instr_raw
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = CW + 3;
    localparam logic [CW:0] DEPTH_W    = (CW+1)'(DEPTH);
    localparam logic [31:0] RESET_BASE = RESET_PC & ~32'h3;

    localparam logic [1:0] BOOT  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    // outstanding counts live-path requests only; stale ones live in drop_cnt
    logic [CW-1:0] outstanding;
    logic [CW-1:0] count;
    logic [DW-1:0] drop_cnt;
    logic [DW-1:0] drop_next;
    logic [DW-1:0] in_flight;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [31:0]   buf_pc   [DEPTH];
    logic [31:0]   buf_word [DEPTH];

    logic          accept;
    logic          consume;
    logic          resp_stale;
    logic          resp_live;
    logic          push;
    logic [CW:0]   credit_use;
    logic [31:0]   redirect_base;

    assign redirect_base = redirect_pc & ~32'h3;

    assign enabled = !rst && (count != '0) && !stall && !redirect_valid;
    assign consume = enabled;

    assign credit_use = {1'b0, outstanding} + {1'b0, count} - {{CW{1'b0}}, consume};

    assign imem_req_valid = !rst && (state != BOOT) && !redirect_valid && (credit_use < DEPTH_W);
    assign imem_req_addr  = fetch_pc;
    assign accept         = imem_req_valid && imem_req_ready;

    assign resp_stale = imem_resp_valid && (drop_cnt != '0);
    assign resp_live  = imem_resp_valid && (drop_cnt == '0) && (outstanding != '0);
    assign push       = resp_live && !redirect_valid && !rst;

    assign pc        = (count != '0) ? buf_pc[rd_ptr]   : '0;
    assign instr_raw = (count != '0) ? buf_word[rd_ptr] : '0;

    // Every request still unanswered after this edge; no request is accepted
    // during a redirect or reset, so only the response term matters.
    assign in_flight = drop_cnt + DW'(outstanding) - DW'(resp_stale || resp_live);

    always_comb begin
        if (rst || redirect_valid) begin
            drop_next = in_flight;
        end else begin
            drop_next = drop_cnt - DW'(resp_stale);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            BOOT:    state_next = (drop_next != '0) ? DRAIN : RUN;
            RUN:     if (drop_next != '0) state_next = DRAIN;
            DRAIN:   if (drop_next == '0) state_next = RUN;
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BOOT;
            fetch_pc    <= RESET_BASE;
            resp_pc     <= RESET_BASE;
            outstanding <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            drop_cnt    <= drop_next;
        end else begin
            state    <= state_next;
            drop_cnt <= drop_next;
            if (redirect_valid) begin
                fetch_pc    <= redirect_base;
                resp_pc     <= redirect_base;
                outstanding <= '0;
                count       <= '0;
                rd_ptr      <= '0;
                wr_ptr      <= '0;
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                outstanding <= outstanding + CW'(accept) - CW'(resp_live);
                if (push) begin
                    resp_pc <= resp_pc + 32'd4;
                    wr_ptr  <= wr_ptr + AW'(1);
                end
                if (consume) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                count <= count + CW'(push) - CW'(consume);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc[wr_ptr]   <= resp_pc;
            buf_word[wr_ptr] <= imem_resp_data;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model with variable latency, epoch-tagged
// requests to identify stale responses, and a queue model of buffered instructions.
module tb_fetch_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        enabled;
    logic [31:0] pc;
    logic [31:0] instr_raw;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .stall           (stall),
        .enabled         (enabled),
        .pc              (pc),
        .instr_raw       (instr_raw)
    );

    always #5 clk = ~clk;

    int          cyc      = 0;
    int          n_cmp    = 0;
    int          n_err    = 0;
    int          lat      = 1;
    int          last_due = -1;
    int          cur_ep   = 0;
    logic        prev_rst = 1'b0;
    logic [31:0] req_exp  = RESET_PC;

    int          mem_due  [$];
    logic [31:0] mem_addr [$];
    int          mem_ep   [$];
    logic [63:0] exp_q    [$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_A5A5;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, sample at negedge, advance the model.
    task automatic step(input logic r, input logic rdy, input logic st,
                        input logic rv, input logic [31:0] rpc);
        logic        deliver;
        logic        boot;
        logic        exp_en;
        logic        exp_valid;
        logic [31:0] r_addr;
        logic [31:0] exp_pc;
        logic [31:0] exp_word;
        int          r_ep;
        int          live;
        int          due;

        deliver = (mem_due.size() > 0) && (mem_due[0] == cyc);
        r_addr  = deliver ? mem_addr[0] : 32'h0;
        r_ep    = deliver ? mem_ep[0] : -1;

        rst             = r;
        imem_req_ready  = rdy;
        stall           = st;
        redirect_valid  = rv;
        redirect_pc     = rpc;
        imem_resp_valid = deliver;
        imem_resp_data  = deliver ? mem_word(r_addr) : $urandom();

        @(negedge clk);
        boot   = prev_rst && !r;
        exp_en = !r && (exp_q.size() > 0) && !st && !rv;
        live   = 0;
        foreach (mem_ep[i]) if (mem_ep[i] == cur_ep) live++;
        exp_valid = !r && !boot && !rv && ((live + exp_q.size() - (exp_en ? 1 : 0)) < DEPTH);

        check("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_valid});
        check("enabled", {31'b0, enabled}, {31'b0, exp_en});
        if (!r) begin
            exp_pc   = (exp_q.size() > 0) ? exp_q[0][63:32] : 32'h0;
            exp_word = (exp_q.size() > 0) ? exp_q[0][31:0]  : 32'h0;
            check("req_addr", imem_req_addr, req_exp);
            check("pc", pc, exp_pc);
            check("instr_raw", instr_raw, exp_word);
        end

        if (exp_en) void'(exp_q.pop_front());

        if (imem_req_valid && rdy) begin
            due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            last_due = due;
            mem_due.push_back(due);
            mem_addr.push_back(imem_req_addr);
            mem_ep.push_back(cur_ep);
            req_exp = req_exp + 32'd4;
        end

        if (deliver) begin
            void'(mem_due.pop_front());
            void'(mem_addr.pop_front());
            void'(mem_ep.pop_front());
            if (!r && !rv && r_ep == cur_ep) exp_q.push_back({r_addr, mem_word(r_addr)});
        end

        if (r) begin
            exp_q.delete();
            cur_ep++;
            req_exp = RESET_PC;
        end else if (rv) begin
            exp_q.delete();
            cur_ep++;
            req_exp = rpc & ~32'h3;
        end
        prev_rst = r;

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        logic        r;
        logic        rdy;
        logic        st;
        logic        rv;
        logic [31:0] rpc;

        rst = 1'b1;
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        stall = 1'b0;

        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        lat = 1;
        run(20);

        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        run(10);

        for (int i = 0; i < 16; i++) step(1'b0, (i % 2) == 0, 1'b0, 1'b0, 32'h0);
        run(4);

        lat = 3;
        run(8);
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0100);
        run(12);

        lat = 1;
        run(5);
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0203);
        run(10);

        step(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
        run(8);
        lat = 2;
        run(6);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        run(12);

        for (int i = 0; i < 3000; i++) begin
            if ((i % 50) == 0) lat = $urandom_range(1, 4);
            r   = ($urandom_range(0, 199) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            st  = ($urandom_range(0, 4) == 0);
            rv  = ($urandom_range(0, 29) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                              : $urandom();
            step(r, rdy, st, rv, rpc);
        end
        run(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
